pmod_debouncer: RTL
===================

PMOD_DEBOUNCER -- requirements
Module: pmod_debouncer

Interface
REQ-001 Parameter CHANNELS, default 4: number of independent input channels.
REQ-002 Parameter DEBOUNCE_CYCLES, default 750000: consecutive stable clock cycles required to accept a change; legal range >= 2.
REQ-003 Parameter ACTIVE_LOW, default 1: when 1, a raw pin level of 0 means asserted.
REQ-004 clock  input  1  system clock; all state changes on its rising edge.
REQ-005 reset  input  1  synchronous, active-high reset.
REQ-006 pins_in  input  CHANNELS  raw asynchronous PMOD pin levels.
REQ-007 level  output  CHANNELS  debounced, normalized level; 1 = asserted.
REQ-008 pressed  output  CHANNELS  one-cycle pulse when level rises.
REQ-009 released  output  CHANNELS  one-cycle pulse when level falls.

Function
REQ-010 Each bit of pins_in SHALL pass through a 2-flop synchronizer, then be normalized (inverted when ACTIVE_LOW=1) to s[i].
REQ-011 Each channel SHALL run an independent FSM with states OFF, SETTLE_ON, ON, SETTLE_OFF and a settle counter of width $clog2(DEBOUNCE_CYCLES).
REQ-012 OFF: s=1 -> SETTLE_ON with count=1; else stay, count=0.
REQ-013 SETTLE_ON: s=0 -> OFF, count=0; s=1 and count=DEBOUNCE_CYCLES-1 -> ON; otherwise count+1.
REQ-014 ON: s=0 -> SETTLE_OFF with count=1; else stay.
REQ-015 SETTLE_OFF: s=1 -> ON, count=0; s=0 and count=DEBOUNCE_CYCLES-1 -> OFF; otherwise count+1.
REQ-016 level[i] SHALL be a registered output, 1 exactly in ON and SETTLE_OFF.
REQ-017 pressed[i] SHALL be 1 for exactly the one cycle in which level[i] first reads 1 after reading 0; released[i] likewise on the 1->0 transition.
REQ-018 Latency: for a clean edge, level SHALL change exactly DEBOUNCE_CYCLES+2 clock cycles after the first rising edge that samples the new raw value.
REQ-019 Any bounce during settle SHALL return the FSM to its stable state and restart the count; no pulse SHALL be produced.
REQ-020 The counter SHALL never wrap; it SHALL be bounded by DEBOUNCE_CYCLES-1.
REQ-021 pressed and released SHALL never both be 1 on the same channel in the same cycle.
REQ-022 Channels SHALL NOT interact; simultaneous changes on several channels SHALL each be processed independently.

Reset
REQ-023 With reset=1 at a clock edge, all synchronizer flops SHALL load the deasserted raw value (1 when ACTIVE_LOW=1), all FSMs SHALL enter OFF, counters SHALL clear to 0, and level, pressed and released SHALL be 0.
REQ-024 A reset during SETTLE_ON or SETTLE_OFF SHALL abandon the settle without producing a pulse; a reset while ON SHALL NOT produce released.
REQ-025 After reset is released, an input held asserted SHALL be accepted through the normal REQ-018 path.

Structure
REQ-026 Package pmod_debouncer_pkg SHALL hold the FSM state encoding constants (OFF, SETTLE_ON, ON, SETTLE_OFF, 2 bits).
REQ-027 The single-channel synchronizer, FSM, counter and pulse logic SHALL form sub-module debounce_channel; pmod_debouncer instantiates CHANNELS copies through a generate loop.

Verification (DEBOUNCE_CYCLES=4, CHANNELS=4, ACTIVE_LOW=1)
REQ-028 Reset with pins_in=4'b1111 -> level=0, pressed=0, released=0 for every cycle while reset=1 and afterwards.
REQ-029 pins_in[0] driven 0 and held for 12 cycles -> level[0]=1 exactly 6 cycles after the first sampling edge; pressed[0]=1 for that one cycle only.
REQ-030 pins_in[0] pattern 0,0,0,1,0 then held at 0 -> no pulse during the bounce; level[0] rises 6 cycles after the final 1->0 edge.
REQ-031 From ON, pins_in[0] returned to 1 and held -> level[0] falls after 6 cycles; released[0] pulses exactly once.
REQ-032 pins_in[3:0]=4'b0000 on the same edge -> all four pressed bits pulse together on the same cycle; level=4'b1111.
REQ-033 reset asserted mid-SETTLE_ON, then released with pin still held at 0 -> no pulse during reset; pressed fires 6 cycles after reset deasserts.

Source files
------------

// File: rtl/pmod_debouncer_pkg.sv
// Shared definitions for the PMOD input debouncer.
//   deb_state_t     : per-channel debounce FSM state (2-bit encoding)
//   state_is_high() : true for states in which the debounced level reads 1
package pmod_debouncer_pkg;

  typedef enum logic [1:0] {
    OFF        = 2'b00,
    SETTLE_ON  = 2'b01,
    ON         = 2'b10,
    SETTLE_OFF = 2'b11
  } deb_state_t;

  // SETTLE_OFF still reports asserted: the release has not been accepted yet.
  function automatic logic state_is_high(input deb_state_t st);
    return (st == ON) || (st == SETTLE_OFF);
  endfunction

endpackage

// File: rtl/debounce_channel.sv
// Single-channel debouncer: 2-flop synchronizer, polarity normalization,
// settle FSM with a bounded counter, and registered level/edge pulses.
// Ports:
//   clock    : system clock, rising edge
//   reset    : synchronous active-high reset
//   pin      : raw asynchronous pin level
//   level    : debounced, normalized level (1 = asserted)
//   pressed  : one-cycle pulse on level 0->1
//   released : one-cycle pulse on level 1->0
module debounce_channel
  import pmod_debouncer_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 750000,
  parameter int unsigned ACTIVE_LOW      = 1
) (
  input  logic clock,
  input  logic reset,
  input  logic pin,
  output logic level,
  output logic pressed,
  output logic released
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  // Raw level that means "not asserted"; synchronizers reset to it.
  localparam logic IDLE_RAW = (ACTIVE_LOW != 0) ? 1'b1 : 1'b0;

  logic [1:0]    sync;
  logic          s;
  deb_state_t    state;
  logic [CW-1:0] count;

  always_ff @(posedge clock) begin
    if (reset) begin
      sync <= {2{IDLE_RAW}};
    end else begin
      sync <= {sync[0], pin};
    end
  end

  assign s = sync[1] ^ IDLE_RAW;

  // level is registered from the state, so it trails the FSM by one cycle;
  // the pulses are derived from the same next/previous level pair so they
  // line up exactly with the level transition.
  always_ff @(posedge clock) begin
    if (reset) begin
      state    <= OFF;
      count    <= '0;
      level    <= 1'b0;
      pressed  <= 1'b0;
      released <= 1'b0;
    end else begin
      level    <= state_is_high(state);
      pressed  <= state_is_high(state) & ~level;
      released <= ~state_is_high(state) & level;

      unique case (state)
        OFF: begin
          if (s) begin
            state <= SETTLE_ON;
            count <= CW'(1);
          end else begin
            count <= '0;
          end
        end
        SETTLE_ON: begin
          if (!s) begin
            state <= OFF;
            count <= '0;
          end else if (count == LAST) begin
            state <= ON;
            count <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end
        ON: begin
          if (!s) begin
            state <= SETTLE_OFF;
            count <= CW'(1);
          end
        end
        SETTLE_OFF: begin
          if (s) begin
            state <= ON;
            count <= '0;
          end else if (count == LAST) begin
            state <= OFF;
            count <= '0;
          end else begin
            count <= count + 1'b1;
          end
        end
        default: begin
          state <= OFF;
          count <= '0;
        end
      endcase
    end
  end

endmodule

// File: rtl/pmod_debouncer.sv
// Multi-channel PMOD input debouncer; each channel is fully independent.
// Ports:
//   clock    : system clock, rising edge
//   reset    : synchronous active-high reset
//   pins_in  : raw asynchronous PMOD pin levels [CHANNELS]
//   level    : debounced, normalized levels (1 = asserted) [CHANNELS]
//   pressed  : one-cycle pulse per channel when level rises [CHANNELS]
//   released : one-cycle pulse per channel when level falls [CHANNELS]
module pmod_debouncer
  import pmod_debouncer_pkg::*;
#(
  parameter int unsigned CHANNELS        = 4,
  parameter int unsigned DEBOUNCE_CYCLES = 750000,
  parameter int unsigned ACTIVE_LOW      = 1
) (
  input  logic                clock,
  input  logic                reset,
  input  logic [CHANNELS-1:0] pins_in,
  output logic [CHANNELS-1:0] level,
  output logic [CHANNELS-1:0] pressed,
  output logic [CHANNELS-1:0] released
);

  for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
      .ACTIVE_LOW     (ACTIVE_LOW)
    ) u_ch (
      .clock   (clock),
      .reset   (reset),
      .pin     (pins_in[i]),
      .level   (level[i]),
      .pressed (pressed[i]),
      .released(released[i])
    );
  end

endmodule
